// File: rtl/disp_pkg.sv
// Shared definitions for the display scan blocks: default brightness width,
// digit index type and the anode polarity helper.
package disp_pkg;

   localparam int unsigned BRIGHT_W_DEF = 4;
   localparam int unsigned MAX_DIGITS   = 32;
   localparam int unsigned DIGIT_IDX_W  = 5;

   typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

   // One-hot anode word for digit idx, inverted for active-low anodes.
   // Callers truncate the result to their own digit count.
   function automatic logic [MAX_DIGITS-1:0] onehot_anode(input digit_idx_t idx,
                                                         input logic       active_low);
      logic [MAX_DIGITS-1:0] v;
      v = MAX_DIGITS'(1) << idx;
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell counter for one scan slot with slot start/end ticks.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   en            count enable; 0 freezes the counter
//   cnt           current position inside the slot, 0..DWELL_CYCLES-1
//   slot_start_c  combinational: enabled cycle with cnt==0
//   slot_end_c    combinational: enabled cycle with cnt==DWELL_CYCLES-1
module scan_tick_gen #(
   parameter int unsigned DWELL_CYCLES = 80000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   output logic [$clog2(DWELL_CYCLES)-1:0] cnt,
   output logic                            slot_start_c,
   output logic                            slot_end_c
);

   localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);

   logic [CNT_W-1:0] cnt_d;

   assign slot_start_c = en && (cnt == '0);
   assign slot_end_c   = en && (cnt == CNT_W'(DWELL_CYCLES - 1));

   // Next count: hold while disabled, wrap at the end of the slot.
   always_comb begin
      cnt_d = cnt;
      if (en) begin
         cnt_d = slot_end_c ? '0 : cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment / LED anode scanner with guard time, PWM brightness,
// per-digit blanking, enable/freeze and slot/frame strobes.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   en            scan enable; 0 freezes scan state and blanks the anodes
//   blank_mask    bit i set keeps digit i dark (latched at slot start)
//   brightness    PWM duty, 0 = off, all-ones = full (latched at slot start)
//   anode         one-hot anode drive, polarity set by AN_ACTIVE_LOW
//   digit_sel     index of the slot being shown, for the segment data mux
//   digit_strobe  one-cycle pulse on the first cycle of each slot
//   frame_done    one-cycle pulse on the first cycle of slot 0
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned N_DIGITS      = 4,
   parameter int unsigned DWELL_CYCLES  = 80000,
   parameter int unsigned GUARD_CYCLES  = 2,
   parameter int unsigned BRIGHT_W      = BRIGHT_W_DEF,
   parameter bit          AN_ACTIVE_LOW = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [N_DIGITS-1:0]         blank_mask,
   input  logic [BRIGHT_W-1:0]         brightness,
   output logic [N_DIGITS-1:0]         anode,
   output logic [$clog2(N_DIGITS)-1:0] digit_sel,
   output logic                        digit_strobe,
   output logic                        frame_done
);

   localparam int unsigned CNT_W   = $clog2(DWELL_CYCLES);
   localparam int unsigned DIG_W   = $clog2(N_DIGITS);
   localparam int unsigned PWM_MAX = (1 << BRIGHT_W) - 2;
   localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

   // Reject parameter sets the scan cannot honour.
   if (GUARD_CYCLES + 1 >= DWELL_CYCLES) begin : g_bad_guard
      $error("display_scan_ctrl: GUARD_CYCLES must be < DWELL_CYCLES-1");
   end
   if (N_DIGITS < 2 || N_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("display_scan_ctrl: N_DIGITS must be in 2..32");
   end

   logic [CNT_W-1:0]    cnt;
   logic                slot_start_c;
   logic                slot_end_c;

   logic [DIG_W-1:0]    digit,  digit_d;
   logic [BRIGHT_W-1:0] pwm,    pwm_d;
   logic [BRIGHT_W-1:0] b_q,    b_d;
   logic [N_DIGITS-1:0] mask_q, mask_d;

   logic [N_DIGITS-1:0] anode_d;
   logic [DIG_W-1:0]    sel_d;
   logic                strobe_d;
   logic                frame_d;
   logic                past_guard_c;
   logic                lit_c;

   scan_tick_gen #(
      .DWELL_CYCLES (DWELL_CYCLES)
   ) u_tick (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .cnt          (cnt),
      .slot_start_c (slot_start_c),
      .slot_end_c   (slot_end_c)
   );

   // Next scan state and next output values.
   always_comb begin
      digit_d  = digit;
      pwm_d    = pwm;
      b_d      = b_q;
      mask_d   = mask_q;
      anode_d  = AN_OFF;
      sel_d    = digit;
      strobe_d = 1'b0;
      frame_d  = 1'b0;

      past_guard_c = (cnt >= CNT_W'(GUARD_CYCLES));
      // pwm never exceeds 2**BRIGHT_W-2, so an all-ones duty is always lit.
      lit_c = en && past_guard_c && !mask_q[digit] && (pwm < b_q);

      if (slot_start_c) begin
         b_d      = brightness;
         mask_d   = blank_mask;
         pwm_d    = '0;
         strobe_d = 1'b1;
         frame_d  = (digit == '0);
      end else if (en && past_guard_c) begin
         pwm_d = (pwm == BRIGHT_W'(PWM_MAX)) ? '0 : pwm + BRIGHT_W'(1);
      end

      if (slot_end_c) begin
         digit_d = (digit == DIG_W'(N_DIGITS - 1)) ? '0 : digit + DIG_W'(1);
      end

      if (lit_c) begin
         anode_d = N_DIGITS'(onehot_anode(digit_idx_t'(digit), AN_ACTIVE_LOW));
      end
   end

   // Scan state and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         digit        <= '0;
         pwm          <= '0;
         b_q          <= '0;
         mask_q       <= '0;
         anode        <= AN_OFF;
         digit_sel    <= '0;
         digit_strobe <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         digit        <= digit_d;
         pwm          <= pwm_d;
         b_q          <= b_d;
         mask_q       <= mask_d;
         anode        <= anode_d;
         digit_sel    <= sel_d;
         digit_strobe <= strobe_d;
         frame_done   <= frame_d;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a slot-arithmetic reference model checked
// every cycle, plus directed literal expectations at key points.
module tb_display_scan_ctrl;

   localparam int ND    = 4;
   localparam int DWELL = 10;
   localparam int GUARD = 2;
   localparam int BW    = 2;
   localparam int PER   = (1 << BW) - 1;

   logic          clk;
   logic          rst;
   logic          en;
   logic [ND-1:0] blank_mask;
   logic [BW-1:0] brightness;
   logic [ND-1:0] anode;
   logic [1:0]    digit_sel;
   logic          digit_strobe;
   logic          frame_done;

   display_scan_ctrl #(
      .N_DIGITS      (ND),
      .DWELL_CYCLES  (DWELL),
      .GUARD_CYCLES  (GUARD),
      .BRIGHT_W      (BW),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .blank_mask   (blank_mask),
      .brightness   (brightness),
      .anode        (anode),
      .digit_sel    (digit_sel),
      .digit_strobe (digit_strobe),
      .frame_done   (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: t counts enabled cycles since reset release; slot
   // position, digit and PWM phase all follow from t by division.
   int            t;
   logic [BW-1:0] b_l;
   logic [ND-1:0] m_l;
   logic [ND-1:0] exp_an;
   logic [1:0]    exp_sel;
   logic          exp_ds;
   logic          exp_fd;
   bit            model_valid = 1'b0;

   function automatic logic [ND-1:0] model_anode(input int tt, input logic [BW-1:0] b,
                                                 input logic [ND-1:0] m);
      int            c;
      int            d;
      logic [ND-1:0] on;
      c = tt % DWELL;
      d = (tt / DWELL) % ND;
      if (c >= GUARD && !m[d] && ((c - GUARD) % PER) < int'(b)) begin
         on = ND'(1) << d;
         return ~on;
      end
      return '1;
   endfunction

   always @(posedge clk) begin
      model_valid <= 1'b1;
      if (!rst) begin
         t       <= 0;
         exp_an  <= '1;
         exp_sel <= '0;
         exp_ds  <= 1'b0;
         exp_fd  <= 1'b0;
      end else if (en) begin
         exp_an  <= model_anode(t, b_l, m_l);
         exp_sel <= 2'((t / DWELL) % ND);
         exp_ds  <= (t % DWELL == 0);
         exp_fd  <= (t % (DWELL * ND) == 0);
         if (t % DWELL == 0) begin
            b_l <= brightness;
            m_l <= blank_mask;
         end
         t <= t + 1;
      end else begin
         exp_an  <= '1;
         exp_sel <= 2'((t / DWELL) % ND);
         exp_ds  <= 1'b0;
         exp_fd  <= 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_anode",  32'(anode),        32'(exp_an));
         chk("model_sel",    32'(digit_sel),    32'(exp_sel));
         chk("model_strobe", 32'(digit_strobe), 32'(exp_ds));
         chk("model_frame",  32'(frame_done),   32'(exp_fd));
      end
   end

   task automatic wait_out(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b0;
      en         = 1'b0;
      blank_mask = '0;
      brightness = 2'd3;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_anode",  32'(anode),        32'hF);
      chk("rst_sel",    32'(digit_sel),    32'd0);
      chk("rst_strobe", 32'(digit_strobe), 32'd0);
      chk("rst_frame",  32'(frame_done),   32'd0);
      rst = 1'b1;
      en  = 1'b1;

      // Full brightness scan: guard then one-hot per slot.
      wait_out(1);   // t=0
      chk("first_strobe", 32'(digit_strobe), 32'd1);
      chk("first_frame",  32'(frame_done),   32'd1);
      chk("first_guard",  32'(anode),        32'hF);
      wait_out(2);   // t=2
      chk("slot0_lit", 32'(anode), 32'hE);
      wait_out(10);  // t=12
      chk("slot1_lit", 32'(anode), 32'hD);
      chk("slot1_sel", 32'(digit_sel), 32'd1);
      wait_out(10);  // t=22
      chk("slot2_lit", 32'(anode), 32'hB);
      wait_out(10);  // t=32
      chk("slot3_lit", 32'(anode), 32'h7);
      wait_out(8);   // t=40
      chk("frame2_done", 32'(frame_done), 32'd1);
      chk("frame2_sel",  32'(digit_sel),  32'd0);

      // B=1: lit on guard+0, +3, +6 only, taking effect at t=50.
      brightness = 2'd1;
      wait_out(12);  // t=52
      chk("b1_on0",  32'(anode), 32'hD);
      wait_out(1);   // t=53
      chk("b1_off1", 32'(anode), 32'hF);
      wait_out(2);   // t=55
      chk("b1_on3",  32'(anode), 32'hD);
      wait_out(3);   // t=58
      chk("b1_on6",  32'(anode), 32'hD);

      // B=0: dark all slot.
      brightness = 2'd0;
      wait_out(4);   // t=62
      chk("b0_dark", 32'(anode), 32'hF);

      // Mask digit 2; slot still strobes and selects.
      brightness = 2'd3;
      blank_mask = 4'b0100;
      wait_out(38);  // t=100
      chk("mask_strobe", 32'(digit_strobe), 32'd1);
      chk("mask_sel",    32'(digit_sel),    32'd2);
      wait_out(2);   // t=102
      chk("mask_dark",   32'(anode),        32'hF);
      wait_out(7);   // t=109
      chk("mask_dark_end", 32'(anode), 32'hF);
      blank_mask = '0;
      wait_out(3);   // t=112
      chk("unmask_lit", 32'(anode), 32'h7);

      // Freeze at cnt=4 of slot 1 for 5 cycles.
      wait_out(21);  // t=133
      en = 1'b0;
      wait_out(1);
      chk("frz_dark", 32'(anode),        32'hF);
      chk("frz_sel",  32'(digit_sel),    32'd1);
      chk("frz_nostb", 32'(digit_strobe), 32'd0);
      wait_out(4);
      chk("frz_sel_end", 32'(digit_sel), 32'd1);
      en = 1'b1;
      wait_out(1);   // t=134
      chk("resume_lit", 32'(anode), 32'hD);
      wait_out(5);   // t=139
      chk("resume_sel", 32'(digit_sel), 32'd1);
      wait_out(1);   // t=140
      chk("resume_next_strobe", 32'(digit_strobe), 32'd1);
      chk("resume_next_sel",    32'(digit_sel),    32'd2);

      // Brightness change mid-slot ignored until the next slot.
      wait_out(4);   // t=144
      brightness = 2'd1;
      wait_out(1);   // t=145
      chk("bchg_keep5", 32'(anode), 32'hB);
      wait_out(1);   // t=146
      chk("bchg_keep6", 32'(anode), 32'hB);
      wait_out(6);   // t=152
      chk("bchg_new_on",  32'(anode), 32'h7);
      wait_out(1);   // t=153
      chk("bchg_new_off", 32'(anode), 32'hF);

      // Reset in the middle of slot 2 for 3 cycles.
      wait_out(30);  // t=183
      chk("pre_rst_sel", 32'(digit_sel), 32'd2);
      rst = 1'b0;
      wait_out(1);
      chk("mid_rst_anode",  32'(anode),        32'hF);
      chk("mid_rst_sel",    32'(digit_sel),    32'd0);
      chk("mid_rst_strobe", 32'(digit_strobe), 32'd0);
      chk("mid_rst_frame",  32'(frame_done),   32'd0);
      wait_out(2);
      chk("mid_rst_hold", 32'(digit_strobe), 32'd0);
      rst = 1'b1;
      wait_out(1);
      chk("rel_strobe", 32'(digit_strobe), 32'd1);
      chk("rel_frame",  32'(frame_done),   32'd1);
      chk("rel_sel",    32'(digit_sel),    32'd0);
      wait_out(2);
      chk("rel_lit", 32'(anode), 32'hE);
      wait_out(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
